// File: rtl/md_seq_unit_pkg.sv
// Shared op codes, FSM state codes and sizing for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package md_seq_unit_pkg;

  localparam int MD_WIDTH  = 32;
  localparam int MD_OP_LEN = 3;

  typedef enum logic [MD_OP_LEN-1:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_MULTU = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_DIVU  = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_FIX  = 2'd2
  } md_st_e;

  // True for the ops that run the iterative datapath.
  function automatic logic md_is_iter(input logic [MD_OP_LEN-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  // True for the two's-complement flavours (MULT, DIV).
  function automatic logic md_is_signed(input logic [MD_OP_LEN-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

  // True for the divide flavours (DIV, DIVU).
  function automatic logic md_is_div(input logic [MD_OP_LEN-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_seq_unit.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO registers.
// Latency: 34 busy cycles (issue, 32 CALC steps, 1 FIX); done pulses in the cycle after FIX.
// Backpressure: none; busy stalls the issuer, start while busy is dropped, cancel aborts.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   start, op       issue request with MD_OP_* code
//   in0, in1        rs (multiplicand/dividend, MTHI/MTLO source) and rt (multiplier/divisor)
//   cancel          abort the in-flight op; also suppresses an issue in the same cycle
//   busy            op in flight, or MULT*/DIV* being issued this cycle (combinational)
//   done            one-cycle pulse when a fresh hi/lo becomes visible
//   hi, lo          HI/LO architectural registers
module md_seq_unit
  import md_seq_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MD_OP_LEN-1:0] op,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  localparam int CW = $clog2(WIDTH);

  md_st_e               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     opb;      // multiplicand or divisor magnitude
  logic                 op_div;
  logic                 neg_res;  // negate product / quotient in FIX
  logic                 neg_rem;  // remainder takes the dividend's sign
  logic                 div_zero;

  // ---------------------------------------------------------------------------
  // Issue decode
  // ---------------------------------------------------------------------------
  logic             idle;
  logic             iter_req;
  logic             issue_iter;
  logic             issue_mthi;
  logic             issue_mtlo;
  logic             op_sgn;
  logic             s0, s1;
  logic [WIDTH-1:0] mag0, mag1;

  assign idle       = (state == MD_ST_IDLE);
  assign iter_req   = start & md_is_iter(op);
  // The hazard unit needs busy in the issue cycle itself, cancel or not.
  assign busy       = ~idle | iter_req;
  assign issue_iter = idle & iter_req & ~cancel;
  assign issue_mthi = idle & start & ~cancel & (op == MD_OP_MTHI);
  assign issue_mtlo = idle & start & ~cancel & (op == MD_OP_MTLO);

  assign op_sgn = md_is_signed(op);
  assign s0     = op_sgn & in0[WIDTH-1];
  assign s1     = op_sgn & in1[WIDTH-1];
  // |-2^(W-1)| wraps to 2^(W-1), which is exactly right read as unsigned.
  assign mag0   = s0 ? (~in0 + WIDTH'(1)) : in0;
  assign mag1   = s1 ? (~in1 + WIDTH'(1)) : in1;

  // ---------------------------------------------------------------------------
  // One iteration step of each algorithm
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_shf;
  logic [WIDTH:0]     div_dif;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    // Add-and-shift: the carry out of the add becomes the new top bit.
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into a W+1-bit partial remainder.
    div_shf = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_dif = div_shf - {1'b0, opb};
    div_ge  = ~div_dif[WIDTH];
    // When the subtract fails, div_shf < divisor, so its top bit is zero.
    div_rem = div_ge ? div_dif[WIDTH-1:0] : div_shf[WIDTH-1:0];
    div_nxt = {div_rem, acc[WIDTH-2:0], div_ge};
  end

  // ---------------------------------------------------------------------------
  // FIX-stage sign correction
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  always_comb begin
    prod_fix = neg_res ? (~acc + (2*WIDTH)'(1)) : acc;
    quo_fix  = neg_res ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (op_div) begin
      hi_res = div_zero ? '0 : rem_fix;
      lo_res = div_zero ? '0 : quo_fix;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MD_ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_ST_IDLE: if (issue_iter) state_nxt = MD_ST_CALC;
      MD_ST_CALC: begin
        if (cancel)           state_nxt = MD_ST_IDLE;
        else if (cnt == '0)   state_nxt = MD_ST_FIX;
      end
      MD_ST_FIX:  state_nxt = MD_ST_IDLE;
      default:    state_nxt = MD_ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and architectural registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == MD_ST_FIX) & ~cancel;

      if (issue_iter) begin
        cnt      <= CW'(WIDTH-1);
        op_div   <= md_is_div(op);
        neg_res  <= s0 ^ s1;
        neg_rem  <= s0;
        div_zero <= (in1 == '0);
        if (md_is_div(op)) begin
          acc <= {{WIDTH{1'b0}}, mag0};
          opb <= mag1;
        end else begin
          acc <= {{WIDTH{1'b0}}, mag1};
          opb <= mag0;
        end
      end

      if (state == MD_ST_CALC && !cancel) begin
        cnt <= cnt - CW'(1);
        acc <= op_div ? div_nxt : mul_nxt;
      end

      if (state == MD_ST_FIX && !cancel) begin
        hi <= hi_res;
        lo <= lo_res;
      end

      if (issue_mthi) hi <= in0;
      if (issue_mtlo) lo <= in0;
    end
  end

endmodule

// File: tb/tb_md_seq_unit.sv
// Self-checking bench for md_seq_unit: directed ops, expected hi/lo pushed to a queue
// at issue time, a done-triggered monitor pops and compares.
module tb_md_seq_unit;
  import md_seq_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in0, in1;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  logic [31:0] cur_hi, cur_lo;   // bench's model of the architectural HI/LO

  md_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in0(in0), .in1(in1),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no pulse (t=%0t)", $time);
      end else begin
        chk("result_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    start  = 1'b0;
    op     = MD_OP_NONE;
    in0    = '0;
    in1    = '0;
    cancel = 1'b0;
  endtask

  // Issue one MULT*/DIV* and follow it to completion. If inj_cyc > 0, a second
  // start (inj_op) is presented in that cycle and must be ignored.
  task automatic run_op(input string name, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int inj_cyc, input logic [2:0] inj_op);
    int nb;
    bit fin;
    @(posedge clk); #1;
    start = 1'b1; op = o; in0 = a; in1 = b;
    exp_q.push_back({eh, el});
    @(negedge clk);
    chk({name, "_busy_issue"}, {63'd0, busy}, 64'd1);
    nb  = 1;
    fin = 0;
    for (int c = 1; c < 100 && !fin; c++) begin
      @(posedge clk); #1;
      if (c == inj_cyc) begin
        start = 1'b1; op = inj_op; in0 = 32'hDEAD_BEEF; in1 = 32'h0000_0001;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (c == 20 || (inj_cyc > 0 && c == inj_cyc + 1))
        chk({name, "_hold_hilo"}, {hi, lo}, {cur_hi, cur_lo});
      if (busy) nb++;
      else      fin = 1;
    end
    chk({name, "_busy_cycles"}, 64'(nb), 64'd34);
    @(negedge clk);
    chk({name, "_done_once"}, {63'd0, done}, 64'd0);
    chk({name, "_consumed"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi",   {32'd0, hi},   64'd0);
    chk("reset_lo",   {32'd0, lo},   64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    cur_hi = '0;
    cur_lo = '0;

    // Multiply, signed and unsigned; MTLO presented mid-MULTU must be dropped.
    run_op("mult_m1x3",  MD_OP_MULT,  32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, MD_OP_NONE);
    run_op("multu_max3", MD_OP_MULTU, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 32'hFFFF_FFFD, 3, MD_OP_MTLO);

    // Divide: signed negative dividend, unsigned, overflow corner, divide by zero.
    run_op("div_m7_2",   MD_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, MD_OP_NONE);
    run_op("divu_7_2",   MD_OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0, MD_OP_NONE);
    run_op("div_min_m1", MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, MD_OP_NONE);
    run_op("div_7_m2",   MD_OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, MD_OP_NONE);
    // MULT presented at cycle 5 of a DIV is lost; DIV result unaffected.
    run_op("div_100_7",  MD_OP_DIV,  32'd100, 32'd7, 32'd2, 32'd14, 5, MD_OP_MULT);
    run_op("divu_5_0",   MD_OP_DIVU, 32'd5, 32'd0, 32'd0, 32'd0, 0, MD_OP_NONE);

    // MTHI / MTLO from IDLE: written next edge, never busy.
    @(posedge clk); #1;
    start = 1'b1; op = MD_OP_MTHI; in0 = 32'h0000_1234;
    @(negedge clk);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b1; op = MD_OP_MTLO; in0 = 32'h0000_5678;
    @(negedge clk);
    chk("mthi_hi",   {32'd0, hi},   64'h1234);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("mtlo_lo",   {32'd0, lo},   64'h5678);
    chk("mt_done",   {63'd0, done}, 64'd0);
    cur_hi = 32'h0000_1234;
    cur_lo = 32'h0000_5678;

    // Cancel a DIV at cycle 10: idle at cycle 11, hi/lo untouched, no done.
    @(posedge clk); #1;
    start = 1'b1; op = MD_OP_DIV; in0 = 32'd100; in1 = 32'd7;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (c == 10) cancel = 1'b1;
      @(negedge clk);
      if (c == 10) chk("cancel_busy_c10", {63'd0, busy}, 64'd1);
      if (c == 11) chk("cancel_busy_c11", {63'd0, busy}, 64'd0);
    end
    repeat (40) @(negedge clk);
    chk("cancel_hilo", {hi, lo}, {cur_hi, cur_lo});

    // cancel together with start in IDLE: busy that cycle, nothing issues.
    @(posedge clk); #1;
    start = 1'b1; op = MD_OP_MULT; in0 = 32'd9; in1 = 32'd9; cancel = 1'b1;
    @(negedge clk);
    chk("cancel_issue_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("cancel_issue_idle", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("cancel_issue_hilo", {hi, lo}, {cur_hi, cur_lo});

    // Reset at cycle 20 of a MULT: immediate clear, no result later.
    @(posedge clk); #1;
    start = 1'b1; op = MD_OP_MULT; in0 = 32'd11; in1 = 32'd13;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      idle_inputs();
    end
    reset = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi, lo},             64'd0);
    chk("rst_mid_busy", {62'd0, busy, done},  64'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    repeat (40) @(negedge clk);
    chk("rst_no_result", {hi, lo}, 64'd0);

    run_op("mult_6x7", MD_OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 0, MD_OP_NONE);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
